vram_arbiter: RTL and testbench

//  Single-port video RAM arbiter between the CPU bus and the MC6847_gen3 VDG fetch port (DA/DD).

---
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VDG fetches on address change, CPU accesses fill idle slots with bounded wait.
// Read data returns two edges after issue; a 2-stage tag pipe routes ram_rdata to its requester.
module vram_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_25,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] vdg_addr,
    output logic [DATA_W-1:0] vdg_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {TAG_NONE, TAG_VDG, TAG_CPU} tag_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [DATA_W-1:0] vdg_data_q, vdg_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0] fetched_addr_q, fetched_addr_d;
    logic              force_fetch_q, force_fetch_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    tag_t              tag0_q, tag0_d;
    tag_t              tag1_q, tag1_d;

    logic cpu_ok, vdg_need, grant_cpu, grant_vdg;

    always_comb begin
        vdg_data_d     = vdg_data_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_ack_d      = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_we_d       = 1'b0;
        ram_wdata_d    = ram_wdata_q;
        fetched_addr_d = fetched_addr_q;
        force_fetch_d  = force_fetch_q;
        cpu_busy_d     = cpu_busy_q;
        wait_cnt_d     = wait_cnt_q;
        tag0_d         = TAG_NONE;
        tag1_d         = tag0_q;

        cpu_ok    = cpu_req && !cpu_busy_q;
        vdg_need  = force_fetch_q || (vdg_addr != fetched_addr_q);
        grant_cpu = 1'b0;
        grant_vdg = 1'b0;
        if (cpu_ok && wait_cnt_q == WAIT_MAX) begin
            grant_cpu = 1'b1;
        end else if (vdg_need) begin
            grant_vdg = 1'b1;
        end else if (cpu_ok) begin
            grant_cpu = 1'b1;
        end

        // Data returning this edge was issued two edges ago.
        if (tag1_q == TAG_VDG) begin
            vdg_data_d = ram_rdata;
        end
        if (tag1_q == TAG_CPU) begin
            cpu_rdata_d = ram_rdata;
            cpu_ack_d   = 1'b1;
            cpu_busy_d  = 1'b0;
        end
        if (ram_we_q) begin
            cpu_ack_d  = 1'b1;
            cpu_busy_d = 1'b0;
            // Snoop overrides any stale VDG return of the same address.
            if (ram_addr_q == fetched_addr_q) begin
                vdg_data_d = ram_wdata_q;
            end
        end

        if (grant_vdg) begin
            ram_addr_d     = vdg_addr;
            fetched_addr_d = vdg_addr;
            force_fetch_d  = 1'b0;
            tag0_d         = TAG_VDG;
        end else if (grant_cpu) begin
            ram_addr_d = cpu_addr;
            ram_we_d   = cpu_we;
            cpu_busy_d = 1'b1;
            tag0_d     = cpu_we ? TAG_NONE : TAG_CPU;
            if (cpu_we) begin
                ram_wdata_d = cpu_wdata;
            end
        end

        if (!cpu_req || grant_cpu) begin
            wait_cnt_d = '0;
        end else if (cpu_ok && wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            vdg_data_q     <= '0;
            cpu_rdata_q    <= '0;
            cpu_ack_q      <= 1'b0;
            ram_addr_q     <= '0;
            ram_we_q       <= 1'b0;
            ram_wdata_q    <= '0;
            fetched_addr_q <= '0;
            force_fetch_q  <= 1'b1;
            cpu_busy_q     <= 1'b0;
            wait_cnt_q     <= '0;
            tag0_q         <= TAG_NONE;
            tag1_q         <= TAG_NONE;
        end else begin
            vdg_data_q     <= vdg_data_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_ack_q      <= cpu_ack_d;
            ram_addr_q     <= ram_addr_d;
            ram_we_q       <= ram_we_d;
            ram_wdata_q    <= ram_wdata_d;
            fetched_addr_q <= fetched_addr_d;
            force_fetch_q  <= force_fetch_d;
            cpu_busy_q     <= cpu_busy_d;
            wait_cnt_q     <= wait_cnt_d;
            tag0_q         <= tag0_d;
            tag1_q         <= tag1_d;
        end
    end

    assign vdg_data  = vdg_data_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous single-port RAM model.
module tb_vram_arbiter;
    logic        clk_25;
    logic        reset_n;
    logic [13:0] vdg_addr;
    logic [7:0]  vdg_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0] mem [0:16383];

    int errors = 0;
    int checks = 0;

    vram_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_WAIT(4)) dut (
        .clk_25    (clk_25),
        .reset_n   (reset_n),
        .vdg_addr  (vdg_addr),
        .vdg_data  (vdg_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk_25 = 1'b0;
        forever #5 clk_25 = ~clk_25;
    end

    // Preload then act as a synchronous RAM (read-before-write).
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0000] = 8'h77;
        mem[14'h0123] = 8'hA5;
        for (int i = 0; i < 16; i++) mem[14'h0300 + i] = 8'h10 + 8'(i);
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk_25);
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        vdg_addr  = 14'h0123;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 14'h0000;
        cpu_wdata = 8'h00;
        tick();
        tick();
        checks++;
        if ({vdg_data, cpu_rdata, ram_addr, ram_wdata, cpu_ack, ram_we} !== 40'd0)
            $display("FAIL reset_outputs: got %h required 0",
                     {vdg_data, cpu_rdata, ram_addr, ram_wdata, cpu_ack, ram_we});
        if ({vdg_data, cpu_rdata, ram_addr, ram_wdata, cpu_ack, ram_we} !== 40'd0) errors++;
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (ram_we !== 1'b0) begin
                errors++;
                $display("FAIL t1_ram_we edge%0d: got %b required 0", k, ram_we);
            end
            if (k == 1) begin
                checks++;
                if (ram_addr !== 14'h0123) begin
                    errors++;
                    $display("FAIL t1_ram_addr: got %h required 0123", ram_addr);
                end
            end
            if (k == 2) begin
                checks++;
                if (vdg_data !== 8'h00) begin
                    errors++;
                    $display("FAIL t1_early_data: got %h required 00", vdg_data);
                end
            end
            if (k == 3) begin
                checks++;
                if (vdg_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL t1_vdg_data: got %h required a5", vdg_data);
                end
            end
        end
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'h5A;
        tick();
        checks++;
        if ({ram_we, ram_addr, ram_wdata, cpu_ack} !== {1'b1, 14'h0200, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL t2_issue: we=%b addr=%h wdata=%h ack=%b required 1/0200/5a/0",
                     ram_we, ram_addr, ram_wdata, cpu_ack);
        end
        tick();
        checks++;
        if ({ram_we, cpu_ack, vdg_data} !== {1'b0, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL t2_ack: we=%b ack=%b vdg=%h required 0/1/a5", ram_we, cpu_ack, vdg_data);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL t2_ack_single: got %b required 0", cpu_ack);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
        tick();
        checks++;
        if ({ram_we, ram_addr, cpu_ack} !== {1'b0, 14'h0200, 1'b0}) begin
            errors++;
            $display("FAIL t3_issue: we=%b addr=%h ack=%b required 0/0200/0", ram_we, ram_addr, cpu_ack);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL t3_early_ack: got %b required 0", cpu_ack);
        end
        tick();
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL t3_rdata: ack=%b rdata=%h required 1/5a", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL t3_ack_single: got %b required 0", cpu_ack);
        end
    endtask

    task automatic test_starvation();
        logic [13:0] exp_addr;
        logic [7:0]  exp_vdg;
        vdg_addr = 14'h0300;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k <= 6) begin
                exp_addr = (k <= 4) ? 14'h0300 + 14'(k - 1) : (k == 5) ? 14'h0200 : 14'h0305;
                checks++;
                if (ram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL t4_slot edge%0d: ram_addr=%h required %h", k, ram_addr, exp_addr);
                end
            end
            checks++;
            if (cpu_ack !== (k == 7)) begin
                errors++;
                $display("FAIL t4_ack edge%0d: got %b required %b", k, cpu_ack, (k == 7));
            end
            if (k == 7) begin
                checks++;
                if (cpu_rdata !== 8'h5A) begin
                    errors++;
                    $display("FAIL t4_rdata: got %h required 5a", cpu_rdata);
                end
                cpu_req = 1'b0;
            end
            if (k >= 3) begin
                case (k)
                    3: exp_vdg = 8'h10;
                    4: exp_vdg = 8'h11;
                    5: exp_vdg = 8'h12;
                    6: exp_vdg = 8'h13;
                    7: exp_vdg = 8'h13;
                    default: exp_vdg = 8'h15;
                endcase
                checks++;
                if (vdg_data !== exp_vdg) begin
                    errors++;
                    $display("FAIL t4_vdg edge%0d: got %h required %h", k, vdg_data, exp_vdg);
                end
            end
            vdg_addr = 14'h0300 + 14'(k);
        end
    endtask

    task automatic test_snoop();
        vdg_addr = 14'h0010;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (vdg_data !== 8'h00) begin
            errors++;
            $display("FAIL t5_settle: got %h required 00", vdg_data);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'hC3;
        tick();
        checks++;
        if ({ram_we, vdg_data} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL t5_issue: we=%b vdg=%h required 1/00", ram_we, vdg_data);
        end
        tick();
        checks++;
        if ({vdg_data, cpu_ack, ram_we} !== {8'hC3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL t5_snoop: vdg=%h ack=%b we=%b required c3/1/0", vdg_data, cpu_ack, ram_we);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if ({vdg_data, ram_addr} !== {8'hC3, 14'h0010}) begin
            errors++;
            $display("FAIL t5_hold: vdg=%h addr=%h required c3/0010", vdg_data, ram_addr);
        end
    endtask

    task automatic test_reset_inflight();
        vdg_addr = 14'h0000;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (vdg_data !== 8'h77) begin
            errors++;
            $display("FAIL t6_settle: got %h required 77", vdg_data);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
        tick();
        checks++;
        if (ram_addr !== 14'h0010) begin
            errors++;
            $display("FAIL t6_issue: ram_addr=%h required 0010", ram_addr);
        end
        reset_n = 1'b0;
        cpu_req = 1'b0;
        tick();
        checks++;
        if ({vdg_data, cpu_rdata, ram_addr, ram_wdata, cpu_ack, ram_we} !== 40'd0) begin
            errors++;
            $display("FAIL t6_zero: got %h required 0",
                     {vdg_data, cpu_rdata, ram_addr, ram_wdata, cpu_ack, ram_we});
        end
        reset_n = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++;
            if ({cpu_ack, ram_we} !== 2'b00) begin
                errors++;
                $display("FAIL t6_no_ack edge%0d: ack=%b we=%b required 0/0", k, cpu_ack, ram_we);
            end
        end
        checks++;
        if (vdg_data !== 8'h77) begin
            errors++;
            $display("FAIL t6_forced_fetch: got %h required 77", vdg_data);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_starvation();
        test_snoop();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
